// File: rtl/adder_tree_pkg.sv
// Shared types and width helpers for the pipelined adder tree with burst accumulation.
package adder_tree_pkg;

    typedef enum logic {IDLE, ACCUM} state_t;

    function automatic int out_bits(input int bits, input int num, input int acc_bits);
        return bits + $clog2(num) + acc_bits;
    endfunction

    function automatic int cnt_bits(input int acc_bits);
        return acc_bits + 1;
    endfunction

    // Width of the partial sums produced by tree level k.
    function automatic int lvl_bits(input int bits, input int k);
        return bits + k + 1;
    endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered level of the adder tree: pairwise full-precision sums plus the
// valid/acc_en/last sideband, all advancing only when en is high.
module adder_tree_stage import adder_tree_pkg::*; #(
    parameter int IN_BITS = 17,
    parameter int IN_NUM  = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic                                   a_valid,
    input  logic                                   a_acc_en,
    input  logic                                   a_last,
    input  logic [IN_NUM*IN_BITS-1:0]              a,
    output logic                                   s_valid,
    output logic                                   s_acc_en,
    output logic                                   s_last,
    output logic [(IN_NUM/2)*lvl_bits(IN_BITS,0)-1:0] s
);

    localparam int S_BITS = lvl_bits(IN_BITS, 0);
    localparam int S_NUM  = IN_NUM / 2;

    logic [S_NUM*S_BITS-1:0] sum_c;

    always_comb begin
        // NOTE: the default assignment before the loop keeps this always_comb latch-free.
        sum_c = '0;
        for (int i = 0; i < S_NUM; i++) begin
            sum_c[i*S_BITS +: S_BITS] = S_BITS'(a[2*i*IN_BITS +: IN_BITS])
                                      + S_BITS'(a[(2*i+1)*IN_BITS +: IN_BITS]);
        end
    end

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid  <= 1'b0;
            s_acc_en <= 1'b0;
            s_last   <= 1'b0;
            s        <= '0;
        end else if (en) begin
            s_valid  <= a_valid;
            s_acc_en <= a_acc_en;
            s_last   <= a_last;
            s        <= sum_c;
        end
    end

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined NUM-lane unsigned adder tree with valid/ready handshake, global stall
// and an optional burst-accumulate mode selected on the first beat of each burst.
module adder_tree_acc import adder_tree_pkg::*; #(
    parameter int BITS     = 17,
    parameter int NUM      = 4,
    parameter int ACC_BITS = 8,
    parameter int SAT      = 0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     valid,
    output logic                                     ready,
    input  logic [NUM*BITS-1:0]                      data_in,
    input  logic                                     last,
    input  logic                                     acc_en,
    output logic [out_bits(BITS,NUM,ACC_BITS)-1:0]   o,
    output logic [cnt_bits(ACC_BITS)-1:0]            count,
    output logic                                     overflow,
    output logic                                     valid_out,
    input  logic                                     ready_out
);

    localparam int L        = $clog2(NUM);
    localparam int OUT_BITS = out_bits(BITS, NUM, ACC_BITS);
    localparam int CNT_BITS = cnt_bits(ACC_BITS);
    localparam int SUM_BITS = BITS + L;

    logic en;
    logic live;

    assign en    = ~valid_out | ready_out;
    assign ready = en & live;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        logic                                        v;
        logic                                        ae;
        logic                                        la;
        logic [((NUM>>k)/2)*lvl_bits(BITS,k)-1:0]    s;
        if (k == 0) begin : g_first
            adder_tree_stage #(.IN_BITS(BITS), .IN_NUM(NUM)) u_stage (
                .clk(clk), .rst(rst), .en(en),
                .a_valid(valid & ready), .a_acc_en(acc_en), .a_last(last), .a(data_in),
                .s_valid(v), .s_acc_en(ae), .s_last(la), .s(s)
            );
        end else begin : g_next
            adder_tree_stage #(.IN_BITS(BITS + k), .IN_NUM(NUM >> k)) u_stage (
                .clk(clk), .rst(rst), .en(en),
                .a_valid(g_lvl[k-1].v), .a_acc_en(g_lvl[k-1].ae), .a_last(g_lvl[k-1].la),
                .a(g_lvl[k-1].s),
                .s_valid(v), .s_acc_en(ae), .s_last(la), .s(s)
            );
        end
    end

    logic                t_valid;
    logic                t_acc_en;
    logic                t_last;
    logic [SUM_BITS-1:0] t_sum;

    assign t_valid  = g_lvl[L-1].v;
    assign t_acc_en = g_lvl[L-1].ae;
    assign t_last   = g_lvl[L-1].la;
    assign t_sum    = g_lvl[L-1].s;

    state_t              state;
    logic [OUT_BITS-1:0] acc;
    logic [CNT_BITS-1:0] cnt;
    logic                ovf;

    logic [OUT_BITS:0]   acc_sum;
    logic [OUT_BITS-1:0] acc_next;
    logic [CNT_BITS-1:0] cnt_next;
    logic                ovf_next;

    // Next accumulator values for a beat arriving in ACCUM; overflow is sticky.
    always_comb begin
        acc_sum  = {1'b0, acc} + (OUT_BITS+1)'(t_sum);
        acc_next = acc_sum[OUT_BITS-1:0];
        ovf_next = ovf;
        if (acc_sum[OUT_BITS]) begin
            ovf_next = 1'b1;
            if (SAT != 0) acc_next = '1;
        end
        cnt_next = cnt + CNT_BITS'(1);
        if (&cnt) begin
            cnt_next = cnt;
            ovf_next = 1'b1;
        end
    end

    // NOTE: result registers are reset as well, so o/count read as zero until the first result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live      <= 1'b0;
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            o         <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            live <= 1'b1;
            if (en) begin
                valid_out <= 1'b0;
                if (t_valid) begin
                    case (state)
                        IDLE: begin
                            if (t_acc_en && !t_last) begin
                                acc   <= OUT_BITS'(t_sum);
                                cnt   <= CNT_BITS'(1);
                                ovf   <= 1'b0;
                                state <= ACCUM;
                            end else begin
                                o         <= OUT_BITS'(t_sum);
                                count     <= CNT_BITS'(1);
                                overflow  <= 1'b0;
                                valid_out <= 1'b1;
                            end
                        end
                        ACCUM: begin
                            if (t_last) begin
                                o         <= acc_next;
                                count     <= cnt_next;
                                overflow  <= ovf_next;
                                valid_out <= 1'b1;
                                acc       <= '0;
                                cnt       <= '0;
                                ovf       <= 1'b0;
                                state     <= IDLE;
                            end else begin
                                acc <= acc_next;
                                cnt <= cnt_next;
                                ovf <= ovf_next;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Scoreboard bench: three configurations of adder_tree_acc share one stimulus stream;
// a spec-level model queues expected results and a monitor checks each delivered result.
module tb_adder_tree_acc;

    localparam int BITS = 17;
    localparam int NUM  = 4;
    localparam int NCFG = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                valid = 1'b0;
    logic                last = 1'b0;
    logic                acc_en = 1'b0;
    logic                ready_out = 1'b1;
    logic [NUM*BITS-1:0] data_in = '0;

    logic [NCFG-1:0] ready_v;
    logic [NCFG-1:0] valid_out_v;
    logic [NCFG-1:0] overflow_v;
    logic [31:0]     o_v     [NCFG];
    logic [15:0]     count_v [NCFG];

    int ab_cfg  [NCFG] = '{8, 1, 1};
    bit sat_cfg [NCFG] = '{0, 1, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int AB = (g == 0) ? 8 : 1;
        localparam int SS = (g == 1) ? 1 : 0;
        localparam int OB = BITS + 2 + AB;
        logic [OB-1:0] o_w;
        logic [AB:0]   c_w;
        adder_tree_acc #(.BITS(BITS), .NUM(NUM), .ACC_BITS(AB), .SAT(SS)) u_dut (
            .clk(clk), .rst(rst), .valid(valid), .ready(ready_v[g]),
            .data_in(data_in), .last(last), .acc_en(acc_en),
            .o(o_w), .count(c_w), .overflow(overflow_v[g]),
            .valid_out(valid_out_v[g]), .ready_out(ready_out)
        );
        assign o_v[g]     = 32'(o_w);
        assign count_v[g] = 16'(c_w);
    end

    int total = 0;
    int bad   = 0;
    bit rnd_stall = 1'b0;

    logic [63:0] exp_q [NCFG][$];
    bit          m_burst [NCFG];
    longint      m_acc   [NCFG];
    int          m_cnt   [NCFG];
    bit          m_ovf   [NCFG];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [63:0] pack(input longint ov, input int c, input bit f);
        return {15'd0, f, 16'(c), 32'(ov)};
    endfunction

    function automatic logic [NUM*BITS-1:0] lanes4(input int a, input int b, input int c, input int d);
        return {17'(d), 17'(c), 17'(b), 17'(a)};
    endfunction

    function automatic longint lane_sum(input logic [NUM*BITS-1:0] d);
        longint s = 0;
        for (int i = 0; i < NUM; i++) s += longint'(d[i*BITS +: BITS]);
        return s;
    endfunction

    // Reference behaviour: per-beat results, or one total per burst with sticky overflow.
    task automatic model_beat(input longint sum, input bit ae, input bit la);
        for (int g = 0; g < NCFG; g++) begin
            longint maxo = (longint'(1) << (BITS + 2 + ab_cfg[g])) - 1;
            int     maxc = (1 << (ab_cfg[g] + 1)) - 1;
            if (!m_burst[g]) begin
                if (!ae || la) exp_q[g].push_back(pack(sum, 1, 1'b0));
                else begin
                    m_burst[g] = 1'b1;
                    m_acc[g]   = sum;
                    m_cnt[g]   = 1;
                    m_ovf[g]   = 1'b0;
                end
            end else begin
                m_acc[g] += sum;
                if (m_acc[g] > maxo) begin
                    m_ovf[g] = 1'b1;
                    m_acc[g] = sat_cfg[g] ? maxo : (m_acc[g] % (maxo + 1));
                end
                if (m_cnt[g] == maxc) m_ovf[g] = 1'b1;
                else m_cnt[g]++;
                if (la) begin
                    exp_q[g].push_back(pack(m_acc[g], m_cnt[g], m_ovf[g]));
                    m_burst[g] = 1'b0;
                end
            end
        end
    endtask

    task automatic send(input logic [NUM*BITS-1:0] d, input bit ae, input bit la);
        int  tries = 0;
        bit  done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            valid = 1'b1; data_in = d; acc_en = ae; last = la;
            #1;
            if (ready_v[0]) begin
                done = 1'b1;
                model_beat(lane_sum(d), ae, la);
            end
            @(posedge clk);
            if (!done && ++tries > 500) begin
                check("send_timeout", 1, 0);
                done = 1'b1;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("%s_o%0d", tag, g), o_v[g], 0);
            check($sformatf("%s_count%0d", tag, g), count_v[g], 0);
        end
        check({tag, "_overflow"}, overflow_v, 0);
        check({tag, "_valid_out"}, valid_out_v, 0);
        check({tag, "_ready"}, ready_v, 0);
    endtask

    always @(negedge clk) begin
        if (rnd_stall) ready_out = ($urandom_range(0, 3) != 0);
    end

    // Monitor: any presented result must match the queue head; pop on transfer.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                for (int g = 0; g < NCFG; g++) begin
                    if (valid_out_v[g]) begin
                        if (exp_q[g].size() == 0) begin
                            check($sformatf("unexpected_valid_out%0d", g), valid_out_v[g], 0);
                        end else begin
                            logic [63:0] e;
                            e = exp_q[g][0];
                            check($sformatf("o%0d", g), o_v[g], e[31:0]);
                            check($sformatf("count%0d", g), count_v[g], e[47:32]);
                            check($sformatf("overflow%0d", g), overflow_v[g], e[48]);
                            if (ready_out) void'(exp_q[g].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        logic [NUM*BITS-1:0] d;

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Per-beat mode and latency.
        send(lanes4(1, 2, 3, 4), 1'b0, 1'b0);
        lat = 1;
        @(negedge clk); valid = 1'b0;
        while (!valid_out_v[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 3);
        send(lanes4(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF), 1'b0, 1'b0);
        idle();
        drain();

        // Three-beat burst.
        for (int b = 0; b < 3; b++) send(lanes4(5, 5, 5, 5), 1'b1, b == 2);
        idle();
        drain();

        // Backpressure with the result held.
        send(lanes4(1, 1, 1, 1), 1'b0, 1'b0);
        idle();
        n = 0;
        while (!valid_out_v[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        ready_out = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            check("stall_ready", ready_v, 0);
            check("stall_valid_out", valid_out_v, 3'b111);
        end
        @(negedge clk);
        ready_out = 1'b1;
        drain();

        rnd_stall = 1'b1;
        for (int k = 1; k <= 8; k++) send(lanes4(k, k, k, k), 1'b0, 1'b0);
        idle();
        drain();

        // Overflow: saturate / wrap in the narrow configs, then a clean burst.
        d = lanes4(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF);
        for (int b = 0; b < 4; b++) send(d, 1'b1, b == 3);
        for (int b = 0; b < 2; b++) send(lanes4(1, 1, 1, 1), 1'b1, b == 1);
        for (int b = 0; b < 260; b++) send(d, 1'b1, b == 259);
        idle();
        drain();

        // Reset in the middle of a burst.
        rnd_stall = 1'b0;
        @(negedge clk);
        ready_out = 1'b1;
        for (int b = 0; b < 2; b++) send(lanes4(9, 9, 9, 9), 1'b1, 1'b0);
        @(negedge clk);
        valid = 1'b0;
        rst = 1'b1;
        for (int g = 0; g < NCFG; g++) m_burst[g] = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(lanes4(1, 1, 1, 1), 1'b1, 1'b1);
        idle();
        drain();

        // acc_en dropped mid-burst is ignored.
        send(lanes4(3, 1, 4, 1), 1'b1, 1'b0);
        send(lanes4(5, 9, 2, 6), 1'b0, 1'b0);
        send(lanes4(5, 3, 5, 8), 1'b1, 1'b1);
        idle();
        drain();

        // Randomised traffic with random stalls and gaps.
        rnd_stall = 1'b1;
        for (int b = 0; b < 200; b++) begin
            d = lanes4($urandom_range(0, 17'h1FFFF), $urandom_range(0, 17'h1FFFF),
                       $urandom_range(0, 17'h1FFFF), $urandom_range(0, 17'h1FFFF));
            send(d, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) idle();
        end
        send(lanes4(2, 2, 2, 2), 1'b1, 1'b1);
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
